// File: rtl/reg_bank_reader.sv
// ---------------------------------------------------------------------------
// reg_bank_reader
//
// Read-side sequencer for the datapath register bank. A start pulse seen in
// IDLE makes the block walk bank addresses 0..DEPTH-1 through a synchronous
// read port with 1-cycle latency. Each captured word is offered on a
// valid/ready stream. A one-cycle done pulse follows acceptance of the last
// word. Every output comes straight from a flop.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      begin a sweep (only looked at in IDLE)
//   abort      synchronous cancel of a sweep in progress
//   rd_en      read strobe to the bank
//   rd_addr    read address to the bank
//   rd_data    bank data, valid the cycle after rd_en
//   out_valid  out_data holds a word
//   out_ready  consumer accepts the word
//   out_data   captured word (keeps its last value after a sweep)
//   out_last   marks the word read from address DEPTH-1
//   busy       high in every state except IDLE
//   done       one-cycle pulse after the last word is accepted
// ---------------------------------------------------------------------------
module reg_bank_reader #(
  parameter int DEPTH = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic          rd_en,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    OUT,
    FIN
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_t        state, state_d;
  logic [AW-1:0] idx, idx_d;
  logic          valid_d;
  logic [DW-1:0] data_d;
  logic          last_d;

  // State and word index register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
    end
  end

  // Next-state and next-output logic. Abort is applied last so it overrides
  // both the handshake and the capture; out_data is deliberately left alone
  // on abort because consumers only trust it while out_valid is high.
  always_comb begin
    state_d = state;
    idx_d   = idx;
    valid_d = out_valid;
    data_d  = out_data;
    last_d  = out_last;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_d = READ;
          idx_d   = '0;
        end
      end
      READ: begin
        state_d = WAIT;
      end
      WAIT: begin
        state_d = OUT;
        data_d  = rd_data;
        valid_d = 1'b1;
        last_d  = (idx == LAST_IDX);
      end
      OUT: begin
        if (out_valid && out_ready) begin
          valid_d = 1'b0;
          if (idx == LAST_IDX) begin
            state_d = FIN;
          end else begin
            idx_d   = idx + AW'(1);
            state_d = READ;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
        idx_d   = '0;
        last_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    if (abort && (state != IDLE)) begin
      state_d = IDLE;
      idx_d   = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
      data_d  = out_data;
    end
  end

  // Output registers, loaded from the next-state values so each output is
  // already correct during the first cycle of the state it belongs to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      rd_en     <= (state_d == READ);
      rd_addr   <= idx_d;
      out_valid <= valid_d;
      out_data  <= data_d;
      out_last  <= last_d;
      busy      <= (state_d != IDLE);
      done      <= (state_d == FIN);
    end
  end

endmodule

// File: tb/tb_reg_bank_reader.sv
// ---------------------------------------------------------------------------
// tb_reg_bank_reader
//
// Self-checking bench for reg_bank_reader. A 32-word bank model feeds the
// main instance; a second DEPTH=4 instance checks the short-sweep timing.
// Each sweep is judged against a plain expectation: words mem[0..n-1] in
// order, out_last only on the final address, and one done pulse in the
// cycle following the last acceptance.
// ---------------------------------------------------------------------------
module tb_reg_bank_reader;

  localparam int DEPTH = 32;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          out_ready = 1'b0;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          done;

  logic          start4 = 1'b0;
  logic          rd_en4;
  logic [1:0]    rd_addr4;
  logic [DW-1:0] rd_data4 = '0;
  logic          out_valid4;
  logic [DW-1:0] out_data4;
  logic          out_last4;
  logic          busy4;
  logic          done4;

  logic [DW-1:0] mem [DEPTH];

  int nCompared   = 0;
  int nMismatched = 0;

  // Sweep observations gathered cycle by cycle.
  int            cyc;
  logic [DW-1:0] gotData [$];
  bit            gotLast [$];
  int            rdAddrs [$];
  int            doneCount;
  int            doneCycle;
  int            lastAcceptEdge;
  int            rdConsecutive;
  bit            prevRe;

  typedef struct {
    int readyPct;
    int restartAt;
    int abortAt;
    int expWords;
    int expDone;
    int randData;
  } vec_t;

  vec_t rows [9];

  always #5 clk = ~clk;

  // Bank model: synchronous read, data one cycle after the strobe.
  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (rd_en4) rd_data4 <= mem[{3'b000, rd_addr4}];
  end

  reg_bank_reader #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy), .done(done)
  );

  reg_bank_reader #(.DEPTH(4), .AW(2), .DW(DW)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(1'b0),
    .rd_en(rd_en4), .rd_addr(rd_addr4), .rd_data(rd_data4),
    .out_valid(out_valid4), .out_ready(1'b1), .out_data(out_data4),
    .out_last(out_last4), .busy(busy4), .done(done4)
  );

  // One comparison; prints a FAIL line on disagreement.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clearMonitor();
    gotData.delete();
    gotLast.delete();
    rdAddrs.delete();
    doneCount      = 0;
    doneCycle      = 0;
    lastAcceptEdge = -1;
    rdConsecutive  = 0;
    prevRe         = 1'b0;
  endtask

  // Drive inputs for one cycle, advance past the edge, record what the
  // edge did and check stall/abort behaviour.
  task automatic applyStimulus(input logic s, input logic a, input logic r);
    logic          acc, re, stall, busyPre;
    logic [DW-1:0] d;
    logic          l;
    int            ra;
    start     = s;
    abort     = a;
    out_ready = r;
    acc     = out_valid && r && !a;
    d       = out_data;
    l       = out_last;
    re      = rd_en;
    ra      = int'(rd_addr);
    stall   = out_valid && !r && !a;
    busyPre = busy;
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      gotData.push_back(d);
      gotLast.push_back(l);
      lastAcceptEdge = cyc;
    end
    if (re) rdAddrs.push_back(ra);
    if (re && prevRe) rdConsecutive++;
    prevRe = re;
    if (done) begin
      doneCount++;
      doneCycle = cyc + 1;
    end
    if (stall) begin
      checkOutput("stall_valid", 64'(out_valid), 64'd1);
      checkOutput("stall_data", 64'(out_data), 64'(d));
      checkOutput("stall_last", 64'(out_last), 64'(l));
      checkOutput("stall_no_rd_en", 64'(rd_en), 64'd0);
    end
    if (a && busyPre) begin
      checkOutput("abort_busy", 64'(busy), 64'd0);
      checkOutput("abort_valid", 64'(out_valid), 64'd0);
      checkOutput("abort_rd_en", 64'(rd_en), 64'd0);
      checkOutput("abort_last", 64'(out_last), 64'd0);
      checkOutput("abort_done", 64'(done), 64'd0);
    end
  endtask

  task automatic fillBank(input int randData);
    for (int i = 0; i < DEPTH; i++)
      mem[i] = (randData != 0) ? $urandom() : (32'hA5A5_0000 + 32'(i));
  endtask

  // Run one table row: start pulse, then cycles until the block is idle.
  task automatic runRow(input vec_t v);
    bit   finished;
    logic r;
    fillBank(v.randData);
    clearMonitor();
    cyc = -1;
    applyStimulus(1'b1, 1'b0, 1'b1);
    finished = 1'b0;
    for (int k = 0; k < 600 && !finished; k++) begin
      r = ($urandom_range(99) < v.readyPct);
      applyStimulus(cyc + 1 == v.restartAt, cyc + 1 == v.abortAt, r);
      if (!busy) finished = 1'b1;
    end
    checkOutput("row_timeout", 64'(finished), 64'd1);
    for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 1'b1);

    checkOutput("word_count", 64'(gotData.size()), 64'(v.expWords));
    foreach (gotData[i]) begin
      checkOutput($sformatf("word%0d_data", i), 64'(gotData[i]), 64'(mem[i]));
      checkOutput($sformatf("word%0d_last", i), 64'(gotLast[i]), 64'(i == DEPTH - 1));
    end
    if (v.expDone == 0) begin
      checkOutput("no_done", 64'(doneCount), 64'd0);
    end else begin
      checkOutput("done_count", 64'(doneCount), 64'd1);
      checkOutput("done_after_last", 64'(doneCycle), 64'(lastAcceptEdge + 1));
      if (v.expDone > 0) checkOutput("done_cycle", 64'(doneCycle), 64'(v.expDone));
    end
    if (v.abortAt == 0) checkOutput("rd_en_count", 64'(rdAddrs.size()), 64'(DEPTH));
    foreach (rdAddrs[j]) checkOutput("rd_addr_seq", 64'(rdAddrs[j]), 64'(j));
    checkOutput("rd_en_single", 64'(rdConsecutive), 64'd0);
    checkOutput("end_busy", 64'(busy), 64'd0);
    checkOutput("end_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    bit found;
    int c4, d4Count, d4Cycle;
    logic [DW-1:0] w4 [$];
    bit l4 [$];
    bit acc4;
    logic [DW-1:0] dd4;
    logic ll4;

    // readyPct, restartAt, abortAt, expWords, expDone, randData
    rows[0] = '{100, 0,  0, 32, 97, 0};
    rows[1] = '{100, 22, 0, 32, 97, 0};
    rows[2] = '{100, 0, 38, 12,  0, 0};
    rows[3] = '{100, 0,  0, 32, 97, 0};
    rows[4] = '{100, 0,  1,  0,  0, 1};
    rows[5] = '{100, 0, 97, 32, 97, 0};
    rows[6] = '{50,  0,  0, 32, -1, 1};
    rows[7] = '{30, 15,  0, 32, -1, 1};
    rows[8] = '{100, 0,  9,  2,  0, 1};

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    checkOutput("reset_rd_en", 64'(rd_en), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    clearMonitor();

    $display("[TB] table rows");
    foreach (rows[i]) runRow(rows[i]);

    $display("[TB] backpressure on word 3");
    fillBank(0);
    clearMonitor();
    cyc = -1;
    applyStimulus(1'b1, 1'b0, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 50 && !found; k++) begin
      if (out_valid && out_data == 32'hA5A5_0003) found = 1'b1;
      else applyStimulus(1'b0, 1'b0, 1'b1);
    end
    checkOutput("bp_reach_word3", 64'(found), 64'd1);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("bp_held_data", 64'(out_data), 64'h0000_0000_A5A5_0003);
    end
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("bp_resume_rd_en", 64'(rd_en), 64'd1);
    checkOutput("bp_resume_addr", 64'(rd_addr), 64'd4);
    found = 1'b0;
    for (int k = 0; k < 200 && !found; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (!busy) found = 1'b1;
    end
    checkOutput("bp_finish", 64'(found), 64'd1);
    checkOutput("bp_words", 64'(gotData.size()), 64'(DEPTH));
    checkOutput("bp_done", 64'(doneCount), 64'd1);

    $display("[TB] asynchronous reset mid-sweep");
    fillBank(1);
    clearMonitor();
    cyc = -1;
    applyStimulus(1'b1, 1'b0, 1'b1);
    found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      if (out_valid && out_data == mem[5]) found = 1'b1;
      else applyStimulus(1'b0, 1'b0, 1'b1);
    end
    checkOutput("rst_reach_word5", 64'(found), 64'd1);
    out_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_rd_en", 64'(rd_en), 64'd0);
    checkOutput("rst_rd_addr", 64'(rd_addr), 64'd0);
    checkOutput("rst_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_data", 64'(out_data), 64'd0);
    checkOutput("rst_last", 64'(out_last), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    doneCount = 0;
    for (int k = 0; k < 4; k++) applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("rst_after_busy", 64'(busy), 64'd0);
    checkOutput("rst_after_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_after_no_done", 64'(doneCount), 64'd0);

    $display("[TB] abort with start in IDLE");
    clearMonitor();
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("idle_abort_busy", 64'(busy), 64'd0);
    checkOutput("idle_abort_rd_en", 64'(rd_en), 64'd0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("idle_abort_stay", 64'(busy), 64'd0);
    checkOutput("idle_abort_no_read", 64'(rdAddrs.size()), 64'd0);

    $display("[TB] DEPTH=4 sweep");
    fillBank(1);
    d4Count = 0;
    d4Cycle = 0;
    start4 = 1'b1;
    @(posedge clk);
    #1;
    start4 = 1'b0;
    c4 = 0;
    for (int k = 0; k < 40; k++) begin
      acc4 = out_valid4;
      dd4  = out_data4;
      ll4  = out_last4;
      @(posedge clk);
      #1;
      c4++;
      if (acc4) begin
        w4.push_back(dd4);
        l4.push_back(ll4);
      end
      if (done4) begin
        d4Count++;
        d4Cycle = c4 + 1;
      end
    end
    checkOutput("d4_words", 64'(w4.size()), 64'd4);
    foreach (w4[i]) begin
      checkOutput($sformatf("d4_word%0d", i), 64'(w4[i]), 64'(mem[i]));
      checkOutput($sformatf("d4_last%0d", i), 64'(l4[i]), 64'(i == 3));
    end
    checkOutput("d4_done_count", 64'(d4Count), 64'd1);
    checkOutput("d4_done_cycle", 64'(d4Cycle), 64'd13);
    checkOutput("d4_idle", 64'(busy4), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
